// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice: opcodes, compare threshold,
// FSM state encoding and the latched operation payload.
package alu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned ID_W   = 2;

    localparam logic [OP_W-1:0] OP_ADD     = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB     = 3'd1;
    localparam logic [OP_W-1:0] OP_AND     = 3'd2;
    localparam logic [OP_W-1:0] OP_XOR     = 3'd3;
    localparam logic [OP_W-1:0] OP_GE      = 3'd4;
    localparam logic [OP_W-1:0] OP_HILO_EQ = 3'd5;
    localparam logic [OP_W-1:0] OP_LOHI_EQ = 3'd6;
    localparam logic [OP_W-1:0] OP_UNDEF   = 3'd7;

    localparam logic [DATA_W-1:0] GE_THRESHOLD = 16'd144;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // One ALU operation as presented by a requester and held while in flight.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } alu_req_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter.
//   req         per-requester request level, held until its done pulse
//   op_bus      3-bit opcode per requester, requester i at [3i+2:3i]
//   a_bus/b_bus 16-bit operands per requester, requester i at [16i+15:16i]
//   done        one-hot completion pulse
//   grant_id    current or last granted requester
//   result/result_zero/op_err  registered outcome of the last operation
//   busy        operation in flight
interface alu_arbiter_if #(
    parameter int unsigned N_REQ = 2
);
    logic [N_REQ-1:0]    req;
    logic [3*N_REQ-1:0]  op_bus;
    logic [16*N_REQ-1:0] a_bus;
    logic [16*N_REQ-1:0] b_bus;
    logic [N_REQ-1:0]    done;
    logic [1:0]          grant_id;
    logic [15:0]         result;
    logic                result_zero;
    logic                op_err;
    logic                busy;

    modport master (
        output req, op_bus, a_bus, b_bus,
        input  done, grant_id, result, result_zero, op_err, busy
    );

    modport slave (
        input  req, op_bus, a_bus, b_bus,
        output done, grant_id, result, result_zero, op_err, busy
    );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 16-bit ALU shared by all requesters.
//   op, a, b  latched operation
//   out_c     ALU result
//   zero_c    zero flag (SUB: result is zero; compare ops: result bit 0)
module alu_arbiter_alu
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] out_c,
    output logic              zero_c
);

    always_comb begin
        out_c  = '0;
        zero_c = 1'b0;
        case (op)
            OP_ADD: out_c = a + b;
            OP_SUB: begin
                out_c  = a - b;
                // a - b wraps to zero exactly when the operands are equal
                zero_c = (a == b);
            end
            OP_AND: out_c = a & b;
            OP_XOR: out_c = a ^ b;
            OP_GE: begin
                out_c  = DATA_W'(a >= GE_THRESHOLD);
                zero_c = (a >= GE_THRESHOLD);
            end
            OP_HILO_EQ: begin
                out_c  = DATA_W'(a[15:8] == b[7:0]);
                zero_c = (a[15:8] == b[7:0]);
            end
            OP_LOHI_EQ: begin
                out_c  = DATA_W'(a[7:0] == b[15:8]);
                zero_c = (a[7:0] == b[15:8]);
            end
            default: begin
                out_c  = '0;
                zero_c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between N_REQ requesters.
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    requester bus (slave side): req/op/a/b in; done, grant_id,
//          result, result_zero, op_err, busy out (all registered)
// Each grant runs IDLE -> EXEC -> RESP: operands latched at the grant edge,
// result captured at the EXEC edge, done pulses during RESP.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);

    if (N_REQ < 2 || N_REQ > 4) begin : g_bad_n_req
        $error("alu_arbiter: N_REQ must be in 2..4");
    end

    state_t            state_q, state_d;
    alu_req_t          lat_q, lat_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [N_REQ-1:0]  done_q, done_d;

    alu_req_t          req_arr [N_REQ];
    logic              hi_found_c, lo_found_c, win_found_c;
    logic [ID_W-1:0]   hi_idx_c, lo_idx_c, win_idx_c;
    alu_req_t          hi_pay_c, lo_pay_c, win_pay_c;
    logic [DATA_W-1:0] alu_out_c;
    logic              alu_zero_c;

    // Slice the flat buses into one payload per requester
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_arr[g] = {bus.op_bus[OP_W*g +: OP_W],
                             bus.a_bus[DATA_W*g +: DATA_W],
                             bus.b_bus[DATA_W*g +: DATA_W]};
    end

    // Round-robin search: the lowest requester above last wins; failing
    // that, the lowest at or below last (the wrapped part of the search).
    always_comb begin
        hi_found_c = 1'b0;
        lo_found_c = 1'b0;
        hi_idx_c   = '0;
        lo_idx_c   = '0;
        hi_pay_c   = '0;
        lo_pay_c   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (bus.req[i] && !hi_found_c && (i > 32'(last_q))) begin
                hi_found_c = 1'b1;
                hi_idx_c   = ID_W'(i);
                hi_pay_c   = req_arr[i];
            end
            if (bus.req[i] && !lo_found_c && (i <= 32'(last_q))) begin
                lo_found_c = 1'b1;
                lo_idx_c   = ID_W'(i);
                lo_pay_c   = req_arr[i];
            end
        end
        win_found_c = hi_found_c | lo_found_c;
        win_idx_c   = hi_found_c ? hi_idx_c : lo_idx_c;
        win_pay_c   = hi_found_c ? hi_pay_c : lo_pay_c;
    end

    // The ALU only ever sees the latched operation
    alu_arbiter_alu alu_core (
        .op     (lat_q.op),
        .a      (lat_q.a),
        .b      (lat_q.b),
        .out_c  (alu_out_c),
        .zero_c (alu_zero_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        grant_d  = grant_q;
        last_d   = last_q;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (win_found_c) begin
                    lat_d   = win_pay_c;
                    grant_d = win_idx_c;
                    last_d  = win_idx_c;
                    busy_d  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = alu_out_c;
                zero_d   = alu_zero_c;
                err_d    = (lat_q.op == OP_UNDEF);
                done_d   = N_REQ'(1) << grant_q;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            lat_q    <= '0;
            grant_q  <= '0;
            last_q   <= ID_W'(N_REQ - 1);
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.done        = done_q;
    assign bus.grant_id    = grant_q;
    assign bus.result      = result_q;
    assign bus.result_zero = zero_q;
    assign bus.op_err      = err_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected completions are queued in grant
// order when requests are issued; a monitor checks every done pulse.
module tb_alu_arbiter;

    localparam int unsigned N = 2;

    typedef struct {
        int unsigned id;
        logic [15:0] res;
        logic        zero;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_arbiter_if #(.N_REQ(N)) bus ();
    alu_arbiter #(.N_REQ(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          last_done_cyc = -1;
    bit          hold_mode = 1'b0;
    bit          auto_drop = 1'b1;
    int unsigned model_last = N - 1;
    logic [2:0]  op_v [N];
    logic [15:0] a_v  [N];
    logic [15:0] b_v  [N];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour of one operation, from the opcode table
    function automatic exp_t model(input int unsigned id, input logic [2:0] op,
                                   input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int   ia = int'(a);
        int   ib = int'(b);
        e.id = id; e.res = 16'd0; e.zero = 1'b0; e.err = 1'b0;
        case (op)
            3'd0: e.res = 16'((ia + ib) % 65536);
            3'd1: begin e.res = 16'((ia - ib + 65536) % 65536); e.zero = (e.res == 16'd0); end
            3'd2: e.res = a & b;
            3'd3: e.res = a ^ b;
            3'd4: e.res = (ia >= 144) ? 16'd1 : 16'd0;
            3'd5: e.res = ((ia / 256) == (ib % 256)) ? 16'd1 : 16'd0;
            3'd6: e.res = ((ia % 256) == (ib / 256)) ? 16'd1 : 16'd0;
            default: e.err = 1'b1;
        endcase
        if (op >= 3'd4 && op <= 3'd6) e.zero = (e.res == 16'd1);
        return e;
    endfunction

    // Monitor: every done pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (!reset && bus.done != '0) begin
            exp_t e;
            done_cnt++;
            check("done_onehot", 32'($onehot(bus.done)), 32'd1);
            check("busy_in_resp", 32'(bus.busy), 32'd1);
            if (sbq.size() == 0) begin
                check("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                e = sbq.pop_front();
                check("done_id", 32'(bus.done), 32'(1) << e.id);
                check("grant_id", 32'(bus.grant_id), e.id);
                check("result", 32'(bus.result), 32'(e.res));
                check("result_zero", 32'(bus.result_zero), 32'(e.zero));
                check("op_err", 32'(bus.op_err), 32'(e.err));
            end
            if (hold_mode && last_done_cyc >= 0)
                check("rr_spacing", 32'(cyc - last_done_cyc), 32'd3);
            last_done_cyc = cyc;
        end
    end

    // One cycle; requesters drop req after seeing their done
    task automatic tick();
        @(negedge clk);
        #1;
        if (auto_drop) bus.req = bus.req & ~bus.done;
    endtask

    task automatic set_op(input int unsigned i, input logic [2:0] op,
                          input logic [15:0] a, input logic [15:0] b);
        op_v[i] = op; a_v[i] = a; b_v[i] = b;
    endtask

    task automatic drive_ops(input logic [N-1:0] mask);
        for (int unsigned i = 0; i < N; i++) begin
            if (mask[i]) begin
                bus.op_bus[3*i +: 3]  = op_v[i];
                bus.a_bus[16*i +: 16] = a_v[i];
                bus.b_bus[16*i +: 16] = b_v[i];
            end
        end
    endtask

    // Queue expectations in round-robin service order, then raise the requests
    task automatic issue_round(input logic [N-1:0] mask);
        int unsigned base;
        base = model_last;
        for (int unsigned k = 1; k <= N; k++) begin
            int unsigned id;
            id = (base + k) % N;
            if (mask[id]) begin
                sbq.push_back(model(id, op_v[id], a_v[id], b_v[id]));
                model_last = id;
            end
        end
        drive_ops(mask);
        bus.req = mask;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((bus.req != '0 || bus.busy) && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) check("idle_timeout", 32'(guard), 32'd0);
    endtask

    task automatic run_one(input int unsigned i, input logic [2:0] op,
                           input logic [15:0] a, input logic [15:0] b);
        set_op(i, op, a, b);
        issue_round(N'(1) << i);
        wait_idle();
        tick();
    endtask

    initial begin
        int target;
        int guard;
        bus.req = '0;
        bus.op_bus = '0;
        bus.a_bus = '0;
        bus.b_bus = '0;
        for (int i = 0; i < N; i++) set_op(i, 3'd0, 16'd0, 16'd0);
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // Reset values
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_grant_id", 32'(bus.grant_id), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_zero", 32'(bus.result_zero), 32'd0);
        check("rst_op_err", 32'(bus.op_err), 32'd0);

        // Single request with latency and busy profile
        set_op(0, 3'd0, 16'h0005, 16'h0003);
        issue_round(2'b01);
        tick();
        check("lat_busy_exec", 32'(bus.busy), 32'd1);
        check("lat_done_exec", 32'(bus.done), 32'd0);
        tick();
        check("lat_done_resp", 32'(bus.done), 32'd1);
        tick();
        check("lat_busy_idle", 32'(bus.busy), 32'd0);
        check("lat_done_idle", 32'(bus.done), 32'd0);
        tick();
        check("result_hold", 32'(bus.result), 32'h0008);

        // SUB zero and wrap
        run_one(0, 3'd1, 16'h1234, 16'h1234);
        run_one(0, 3'd1, 16'h0000, 16'h0001);

        // Compare ops and undefined opcode (last one on requester 1)
        run_one(0, 3'd4, 16'd144, 16'd0);
        run_one(0, 3'd4, 16'd143, 16'd0);
        run_one(0, 3'd5, 16'hAB00, 16'h00AB);
        run_one(0, 3'd6, 16'h00CD, 16'hCD00);
        run_one(1, 3'd7, 16'h1111, 16'h2222);

        // Round robin with both requests held continuously
        set_op(0, 3'd3, 16'hF0F0, 16'h0FF0);
        set_op(1, 3'd2, 16'hFF00, 16'h0F0F);
        for (int n = 0; n < 4; n++) begin
            int unsigned id;
            id = (model_last + 1) % N;
            sbq.push_back(model(id, op_v[id], a_v[id], b_v[id]));
            model_last = id;
        end
        auto_drop = 1'b0;
        hold_mode = 1'b1;
        last_done_cyc = -1;
        target = done_cnt + 4;
        drive_ops(2'b11);
        bus.req = 2'b11;
        guard = 0;
        while (done_cnt < target && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) check("rr_timeout", 32'(guard), 32'd0);
        bus.req = '0;
        hold_mode = 1'b0;
        auto_drop = 1'b1;
        wait_idle();
        tick();

        // Operand stability: bus changes after the grant edge are ignored
        set_op(0, 3'd0, 16'd100, 16'd1);
        issue_round(2'b01);
        tick();
        bus.a_bus[15:0] = 16'hFFFF;
        bus.op_bus[2:0] = 3'd3;
        wait_idle();
        tick();

        // Reset during EXEC drops the operation; requester 1 keeps asking
        set_op(1, 3'd0, 16'd7, 16'd9);
        drive_ops(2'b10);
        bus.req = 2'b10;
        tick();
        check("mid_busy_exec", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        tick();
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_grant_id", 32'(bus.grant_id), 32'd0);
        check("mid_rst_result", 32'(bus.result), 32'd0);
        check("mid_rst_zero", 32'(bus.result_zero), 32'd0);
        check("mid_rst_op_err", 32'(bus.op_err), 32'd0);
        model_last = N - 1;
        sbq.push_back(model(1, op_v[1], a_v[1], b_v[1]));
        model_last = 1;
        reset = 1'b0;
        wait_idle();
        tick();

        // Randomized rounds
        for (int r = 0; r < 60; r++) begin
            logic [N-1:0] mask;
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int unsigned i = 0; i < N; i++) begin
                logic [2:0]  op;
                logic [15:0] a;
                logic [15:0] b;
                op = 3'($urandom_range(0, 7));
                a  = 16'($urandom);
                b  = 16'($urandom);
                if ($urandom_range(0, 3) == 0) a = 16'(142 + $urandom_range(0, 4));
                if ($urandom_range(0, 2) == 0) begin
                    case (op)
                        3'd1: b = a;
                        3'd5: b = {8'($urandom), a[15:8]};
                        3'd6: b = {a[7:0], 8'($urandom)};
                        default: b = b;
                    endcase
                end
                set_op(i, op, a, b);
            end
            issue_round(mask);
            wait_idle();
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end

        tick(); tick();
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
